// File: rtl/sdiv_iter_core.sv
// Sequential non-restoring unsigned divider: 2W-bit dividend magnitude by W-bit
// divisor magnitude, one quotient bit per clock through a shared add/sub path.
module sdiv_iter_core #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*W-1:0] dd_mag,
  input  logic [W-1:0]   dv_mag,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quot,
  output logic [W-1:0]   rema,
  output logic           div_by_zero,
  output logic           overflow,
  output logic [1:0]     state_dbg
);

  // Handshake: start is accepted only in IDLE; busy covers RUN and FIX; done is a
  // one-cycle pulse in DONE with results and flags held until the next acceptance.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W:0]    r;
  logic [W-1:0]  q;
  logic [W-1:0]  d;

  logic [W:0]    d_ext;
  logic [W:0]    r_sh;
  logic [W:0]    r_step;
  logic [W:0]    r_fix;
  logic          hi_ge_dv;

  assign state_dbg = state;
  assign d_ext     = {1'b0, d};
  assign hi_ge_dv  = (dd_mag[2*W-1:W] >= dv_mag);

  always_comb begin
    r_sh   = {r[W-1:0], q[W-1]};
    // Sign of the previous partial remainder picks subtract or add-back.
    r_step = r[W] ? (r_sh + d_ext) : (r_sh - d_ext);
    r_fix  = r[W] ? (r + d_ext) : r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quot        <= '0;
      rema        <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            d           <= dv_mag;
            if (dv_mag == '0) begin
              quot        <= '1;
              rema        <= dd_mag[W-1:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end else if (hi_ge_dv) begin
              // Quotient would need more than W bits.
              quot     <= '1;
              rema     <= '0;
              overflow <= 1'b1;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              r     <= {1'b0, dd_mag[2*W-1:W]};
              q     <= dd_mag[W-1:0];
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          r   <= r_step;
          q   <= {q[W-2:0], ~r_step[W]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          r     <= r_fix;
          quot  <= q;
          rema  <= r_fix[W-1:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdiv_iter_core.sv
// Directed bench for sdiv_iter_core: latency, results, flags, ignored starts,
// mid-operation reset, plus a few bench-generated operands checked by the identity.
module tb_sdiv_iter_core;

  localparam int W = 32;

  logic           clk;
  logic           reset;
  logic           start;
  logic [2*W-1:0] dd_mag;
  logic [W-1:0]   dv_mag;
  logic           busy;
  logic           done;
  logic [W-1:0]   quot;
  logic [W-1:0]   rema;
  logic           div_by_zero;
  logic           overflow;
  logic [1:0]     state_dbg;

  int total;
  int bad;
  logic [2*W-1:0] exp_q[$];

  sdiv_iter_core #(.W(W), .CW(6)) dut (
    .clk(clk), .reset(reset), .start(start), .dd_mag(dd_mag), .dv_mag(dv_mag),
    .busy(busy), .done(done), .quot(quot), .rema(rema),
    .div_by_zero(div_by_zero), .overflow(overflow), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of cycle 1 after acceptance.
  task automatic start_op(input logic [2*W-1:0] dd, input logic [W-1:0] dv);
    @(negedge clk);
    dd_mag = dd;
    dv_mag = dv;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dd_mag = $urandom;
    dv_mag = $urandom;
  endtask

  // Count cycles until done; n_in is the current cycle number.
  task automatic wait_done(input int n_in, output int n_done, output int busy_cnt);
    int n;
    n = n_in;
    busy_cnt = 0;
    while (!done && n < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout observed=0 expected=1");
    end
    n_done = n;
  endtask

  task automatic check_result(input string tag, input logic dz, input logic ov);
    logic [2*W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_sb_empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_quot"}, {32'h0, quot}, {32'h0, e[2*W-1:W]});
      chk({tag, "_rema"}, {32'h0, rema}, {32'h0, e[W-1:0]});
    end
    chk({tag, "_dz"}, {63'h0, div_by_zero}, {63'h0, dz});
    chk({tag, "_ov"}, {63'h0, overflow}, {63'h0, ov});
  endtask

  initial begin
    int nd;
    int bc;
    logic [2*W-1:0] rdd;
    logic [W-1:0]   rdv;
    total  = 0;
    bad    = 0;
    start  = 1'b0;
    dd_mag = '0;
    dv_mag = '0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_done", {63'h0, done}, 64'h0);
    chk("rst_quot", {32'h0, quot}, 64'h0);
    chk("rst_rema", {32'h0, rema}, 64'h0);
    chk("rst_flags", {62'h0, div_by_zero, overflow}, 64'h0);
    chk("rst_state", {62'h0, state_dbg}, 64'h0);
    reset = 1'b0;

    // 100 / 7: busy 33 cycles, done in cycle 34
    exp_q.push_back({32'd14, 32'd2});
    start_op(64'd100, 32'd7);
    chk("t1_busy_c1", {63'h0, busy}, 64'h1);
    wait_done(1, nd, bc);
    chk("t1_done_cyc", 64'(nd), 64'd34);
    chk("t1_busy_cnt", 64'(bc), 64'd33);
    chk("t1_busy_at_done", {63'h0, busy}, 64'h0);
    check_result("t1", 1'b0, 1'b0);
    // start while done is high must be ignored
    dd_mag = 64'd50;
    dv_mag = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    chk("t1_done_pulse", {63'h0, done}, 64'h0);
    @(negedge clk);
    chk("t1_start_in_done_ignored", {63'h0, busy}, 64'h0);
    chk("t1_idle", {62'h0, state_dbg}, 64'h0);
    chk("t1_quot_held", {32'h0, quot}, 64'd14);

    // 2^32 / 3
    exp_q.push_back({32'h5555_5555, 32'd1});
    start_op(64'h0000_0001_0000_0000, 32'd3);
    wait_done(1, nd, bc);
    chk("t2_done_cyc", 64'(nd), 64'd34);
    check_result("t2", 1'b0, 1'b0);

    // 0xFFFFFFFF / 1
    exp_q.push_back({32'hFFFF_FFFF, 32'd0});
    start_op(64'h0000_0000_FFFF_FFFF, 32'd1);
    wait_done(1, nd, bc);
    chk("t3_done_cyc", 64'(nd), 64'd34);
    check_result("t3", 1'b0, 1'b0);

    // overflow: high half equals divisor
    exp_q.push_back({32'hFFFF_FFFF, 32'd0});
    start_op(64'h0000_0007_0000_0000, 32'd7);
    wait_done(1, nd, bc);
    chk("t4_done_cyc", 64'(nd), 64'd1);
    chk("t4_busy_cnt", 64'(bc), 64'd0);
    check_result("t4", 1'b0, 1'b1);

    // divide by zero
    exp_q.push_back({32'hFFFF_FFFF, 32'h1234});
    start_op(64'h1234, 32'd0);
    wait_done(1, nd, bc);
    chk("t5_done_cyc", 64'(nd), 64'd1);
    check_result("t5", 1'b1, 1'b0);

    // flags clear on next normal op
    @(negedge clk);
    exp_q.push_back({32'd3, 32'd1});
    start_op(64'd10, 32'd3);
    wait_done(1, nd, bc);
    check_result("t6", 1'b0, 1'b0);

    // re-pulse start while busy: ignored
    @(negedge clk);
    exp_q.push_back({32'd14, 32'd2});
    start_op(64'd100, 32'd7);
    repeat (8) @(negedge clk);
    dd_mag = 64'd50;
    dv_mag = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(10, nd, bc);
    chk("t7_done_cyc", 64'(nd), 64'd34);
    check_result("t7", 1'b0, 1'b0);

    // reset mid-operation
    @(negedge clk);
    start_op(64'd100, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t8_rst_busy", {63'h0, busy}, 64'h0);
    chk("t8_rst_quot", {32'h0, quot}, 64'h0);
    chk("t8_rst_rema", {32'h0, rema}, 64'h0);
    chk("t8_rst_state", {62'h0, state_dbg}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({32'd4, 32'd1});
    start_op(64'd9, 32'd2);
    wait_done(1, nd, bc);
    chk("t8_done_cyc", 64'(nd), 64'd34);
    check_result("t8", 1'b0, 1'b0);

    // bench-generated operands checked against the division identity
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdv = $urandom | 32'h1;
      if (i < 3) rdv = 32'hFFFF_FFFF - 32'(i);
      rdd = {32'($urandom_range(0, rdv - 1)), 32'($urandom)};
      start_op(rdd, rdv);
      wait_done(1, nd, bc);
      chk("rnd_identity", 64'(quot) * 64'(rdv) + 64'(rema), rdd);
      chk("rnd_rema_lt", {63'h0, (rema < rdv)}, 64'h1);
      chk("rnd_flags", {62'h0, div_by_zero, overflow}, 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
